adder_bist_checker: RTL
=======================

# adder_bist_checker

Hardware self-test engine for the 2-bit `full_adder`. It generates all 32 `{cin, a, b}` input combinations in ascending order, drives them into the adder, samples `sum`/`cout`, and checks each result against an internal reference. It reports pass/fail, an error count and the first failing vector. It sits beside the adder on the FPGA, so the adder can be checked on-board without a simulator.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- `sys_clk`  in  1  single clock; all logic is rising-edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request. Sampled only in IDLE or DONE.
- `dut_a`  out  2  operand a to the adder.
- `dut_b`  out  2  operand b to the adder.
- `dut_cin`  out  1  carry-in to the adder.
- `dut_sum`  in  2  adder sum.
- `dut_cout`  in  1  adder carry-out.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE. Sticky until the next start or reset.
- `pass`  out  1  valid when `done`=1. High iff `err_cnt`==0.
- `err_cnt`  out  6  number of mismatching vectors, range 0..32.
- `fail_valid`  out  1  at least one mismatch has been captured.
- `fail_vec`  out  5  `{cin, a, b}` of the first mismatch.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Transitions:
  - IDLE→RUN on `start`=1.
  - RUN→DONE after vector 31 is sampled.
  - DONE→RUN on `start`=1.
  - `start` is ignored during RUN.
- Entering RUN:
  - `vec` is set to 0.
  - `hold` is set to 0.
  - `err_cnt`, `fail_valid`, `fail_vec` and `pass` are cleared.
- `{dut_cin, dut_a, dut_b}` = `vec` (5-bit register), driven continuously while in RUN.
- In IDLE and DONE the DUT inputs hold 0.
- Expected result:
  - `exp` = `vec[4] + vec[3:2] + vec[1:0]` at 3-bit width, range 0..7.
  - Match when `{dut_cout, dut_sum}` == `exp`.
- Sample edge: the edge on which `hold`==`SETTLE`-1. On this edge:
  - If mismatch, `err_cnt` increments.
  - If mismatch and `fail_valid`==0, `fail_vec` is loaded with `vec` and `fail_valid` is set.
  - `hold` is reset to 0 and `vec` increments.
  - If `vec`==31, the block moves to DONE instead of incrementing, and `pass` is set to (final `err_cnt`==0).
- Otherwise `hold` increments.
- `err_cnt` saturation is not needed: at most 32 mismatches fit in 6 bits.
- Reset values: every output is 0, including `pass`. State is IDLE.

## Timing
- `start` is seen at edge E0. RUN begins after E0, with vector 0 driven in the cycle following E0.
- Vector k is driven for cycles E0+k·`SETTLE` through E0+(k+1)·`SETTLE`-1.
- Vector k is sampled at edge E0+(k+1)·`SETTLE`.
- `done`=1, `busy`=0, and `pass` are valid from the cycle after edge E0+32·`SETTLE`.
- `busy` and `done` are never both high.
- `err_cnt` and `fail_*` update on the sample edge and are visible the next cycle.
- Simultaneous events:
  - `start` on the same edge DONE is entered is ignored, because the block is still in RUN on that edge.
  - `start` held high in DONE restarts on the next edge.
- `sys_rst` mid-run: all state and outputs clear immediately (asynchronously). The block returns to IDLE and no partial result is retained.

## Structure
- Shared package `bist_pkg`:
  - `NUM_VEC`=32.
  - `VEC_W`=5.
  - `CNT_W`=6.
  - State enum: IDLE, RUN, DONE.
- Sub-module `adder_ref_model`:
  - Purely combinational.
  - Inputs: `vec[4:0]`. Output: `exp[2:0]`.
  - Reusable by other adder benches.
- Remaining logic in `adder_bist_checker`:
  - FSM.
  - `vec` counter and `hold` counter.
  - Compare logic.
  - Error and first-fail capture registers.

## Test plan
- Golden `full_adder`, `SETTLE`=1, pulse `start`: `done` rises 32 cycles after the start edge; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- DUT model with `cout` stuck at 0: `err_cnt`=16, `fail_valid`=1, `fail_vec`=5'b00111, `pass`=0.
- DUT model with `sum[0]` stuck at 0: `err_cnt`=16, `fail_vec`=5'b00001.
- `SETTLE`=3 with golden DUT:
  - Each vector is held 3 cycles.
  - `done` rises 96 cycles after start.
  - `pass`=1.
- Assert `sys_rst` while `vec`=10: all outputs are 0 immediately and the state is IDLE. A new `start` runs all 32 vectors from 0.
- Hold `start` high throughout a run: the running sequence is unaffected, and the block restarts once in DONE. A second run after the faulty run, with the DUT fixed, clears `err_cnt` and `fail_valid` and finishes with `pass`=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared constants and state type for the full-adder self-test engine.
package bist_pkg;
    localparam int NUM_VEC = 32;
    localparam int VEC_W   = 5;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden model of the 2-bit full adder: exp = cin + a + b.
module adder_ref_model
    import bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [2:0]       exp
);
    // vec packs {cin, a[1:0], b[1:0]}
    assign exp = {2'b00, vec[4]} + {1'b0, vec[3:2]} + {1'b0, vec[1:0]};
endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive on-board self-test of the 2-bit full adder: sweeps all 32
// {cin, a, b} vectors, compares against a reference and records the result.
module adder_bist_checker
    import bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    output logic [1:0]       dut_a,
    output logic [1:0]       dut_b,
    output logic             dut_cin,
    input  logic [1:0]       dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);
    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] vec;
    logic [3:0]       hold;
    logic [2:0]       exp_res;
    logic             launch;
    logic             sample;
    logic             last;
    logic             mismatch;

    adder_ref_model u_ref (
        .vec (vec),
        .exp (exp_res)
    );

    // start is only honoured outside RUN, so a held start cannot disturb a sweep
    assign launch   = (state != RUN) && start;
    assign sample   = (state == RUN) && (hold == 4'(SETTLE - 1));
    assign last     = (vec == VEC_W'(NUM_VEC - 1));
    assign mismatch = ({dut_cout, dut_sum} != exp_res);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (sample && last) state_next = DONE;
            DONE: if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vec        <= '0;
            hold       <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else if (launch) begin
            vec        <= '0;
            hold       <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (mismatch && !fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
            end
            hold <= '0;
            if (last) begin
                // err_cnt has not yet absorbed this vector's result
                pass <= (err_cnt == '0) && !mismatch;
            end else begin
                vec <= vec + VEC_W'(1);
            end
        end else if (state == RUN) begin
            hold <= hold + 4'd1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign {dut_cin, dut_a, dut_b} = busy ? vec : '0;
endmodule
